// File: rtl/pingpong_transpose_buf.sv
// Two-bank ping-pong NxN block buffer: rows are written into one bank while the
// other bank is streamed out column-wise (TRANSPOSE=1) or row-wise (TRANSPOSE=0).
module pingpong_transpose_buf #(
  parameter int unsigned EW        = 8,
  parameter int unsigned N         = 8,
  parameter bit          TRANSPOSE = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            wr_valid,
  output logic            wr_ready,
  input  logic [N*EW-1:0] wr_data,
  input  logic [N-1:0]    wr_be,
  input  logic            flush,
  output logic            rd_valid,
  input  logic            rd_ready,
  output logic [N*EW-1:0] rd_data,
  output logic            rd_last,
  output logic [1:0]      bank_full
);

  localparam int unsigned AW = $clog2(N);

  // Each entry holds one full row; element c lives at [c*EW +: EW].
  logic [N*EW-1:0] mem [2][N];

  logic            wbank;
  logic            rbank;
  logic [AW-1:0]   wrow;
  logic [AW-1:0]   rcol;
  logic            wr_accept;
  logic            wr_done;
  logic            load;
  logic            rd_done;
  logic [N*EW-1:0] be_mask;
  logic [N*EW-1:0] rd_vec;
  logic [1:0]      full_next;

  assign wr_ready  = ~bank_full[wbank];
  // A row arriving together with flush is dropped, which also blocks the bank swap.
  assign wr_accept = wr_valid & wr_ready & ~flush;
  assign wr_done   = wr_accept & (wrow == AW'(N - 1));
  assign load      = bank_full[rbank] & (~rd_valid | rd_ready);
  assign rd_done   = load & (rcol == AW'(N - 1));

  for (genvar c = 0; c < N; c++) begin : g_be
    assign be_mask[c*EW +: EW] = {EW{wr_be[c]}};
  end

  if (TRANSPOSE) begin : g_col
    for (genvar i = 0; i < N; i++) begin : g_elem
      assign rd_vec[i*EW +: EW] = mem[rbank][i][rcol*EW +: EW];
    end
  end else begin : g_row
    assign rd_vec = mem[rbank][rcol];
  end

  always_ff @(posedge clk) begin
    if (wr_accept)
      mem[wbank][wrow] <= (mem[wbank][wrow] & ~be_mask) | (wr_data & be_mask);
  end

  // Set and clear always address different banks, so both may apply on one edge.
  always_comb begin
    full_next = bank_full;
    if (wr_done) full_next[wbank] = 1'b1;
    if (rd_done) full_next[rbank] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbank     <= 1'b0;
      rbank     <= 1'b0;
      wrow      <= '0;
      rcol      <= '0;
      bank_full <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
      rd_last   <= 1'b0;
    end else begin
      if (flush) begin
        wrow <= '0;
      end else if (wr_accept) begin
        if (wr_done) begin
          wrow  <= '0;
          wbank <= ~wbank;
        end else begin
          wrow <= wrow + 1'b1;
        end
      end

      if (load) begin
        rd_data  <= rd_vec;
        rd_valid <= 1'b1;
        rd_last  <= rd_done;
        if (rd_done) begin
          rcol  <= '0;
          rbank <= ~rbank;
        end else begin
          rcol <= rcol + 1'b1;
        end
      end else if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
        rd_last  <= 1'b0;
      end

      bank_full <= full_next;
    end
  end

endmodule

// File: tb/tb_pingpong_transpose_buf.sv
// Bench for pingpong_transpose_buf: a transposing and a pass-through instance share
// all inputs and are scored against a block-level FIFO reference model.
module tb_pingpong_transpose_buf;

  localparam int N  = 8;
  localparam int EW = 8;
  localparam int W  = N * EW;

  logic         clk      = 1'b0;
  logic         reset    = 1'b1;
  logic         wr_valid = 1'b0;
  logic         flush    = 1'b0;
  logic         rd_ready = 1'b0;
  logic [W-1:0] wr_data  = '0;
  logic [N-1:0] wr_be    = '0;

  logic         t_wr_ready, t_rd_valid, t_rd_last;
  logic [W-1:0] t_rd_data;
  logic [1:0]   t_bank_full;
  logic         p_wr_ready, p_rd_valid, p_rd_last;
  logic [W-1:0] p_rd_data;
  logic [1:0]   p_bank_full;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always #5 clk = ~clk;

  pingpong_transpose_buf #(.EW(EW), .N(N), .TRANSPOSE(1'b1)) dut_t (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(t_wr_ready),
    .wr_data(wr_data), .wr_be(wr_be), .flush(flush), .rd_valid(t_rd_valid),
    .rd_ready(rd_ready), .rd_data(t_rd_data), .rd_last(t_rd_last), .bank_full(t_bank_full)
  );

  pingpong_transpose_buf #(.EW(EW), .N(N), .TRANSPOSE(1'b0)) dut_p (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_ready(p_wr_ready),
    .wr_data(wr_data), .wr_be(wr_be), .flush(flush), .rd_valid(p_rd_valid),
    .rd_ready(rd_ready), .rd_data(p_rd_data), .rd_last(p_rd_last), .bank_full(p_bank_full)
  );

  // Reference model: accepted rows fill NxN blocks in alternating banks; each
  // completed block is queued as N expected vectors in both read orders.
  logic [EW-1:0] mbank [2][N][N];
  int            mw_bank = 0;
  int            mw_row  = 0;
  logic [W-1:0]  mon_tv, mon_pv;
  logic [W-1:0]  exp_t[$], exp_p[$], got_t[$], got_p[$];
  logic          exp_l[$], got_tl[$], got_pl[$];
  int            got_cyc[$];

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      mw_bank = 0;
      mw_row  = 0;
    end else begin
      if (t_rd_valid && rd_ready) begin
        got_t.push_back(t_rd_data); got_tl.push_back(t_rd_last); got_cyc.push_back(cyc);
      end
      if (p_rd_valid && rd_ready) begin
        got_p.push_back(p_rd_data); got_pl.push_back(p_rd_last);
      end
      if (flush) begin
        mw_row = 0;
      end else if (wr_valid && t_wr_ready) begin
        for (int c = 0; c < N; c++)
          if (wr_be[c]) mbank[mw_bank][mw_row][c] = wr_data[c*EW +: EW];
        if (mw_row == N - 1) begin
          for (int v = 0; v < N; v++) begin
            for (int i = 0; i < N; i++) begin
              mon_tv[i*EW +: EW] = mbank[mw_bank][i][v];
              mon_pv[i*EW +: EW] = mbank[mw_bank][v][i];
            end
            exp_t.push_back(mon_tv); exp_p.push_back(mon_pv); exp_l.push_back(v == N - 1);
          end
          mw_bank = 1 - mw_bank;
          mw_row  = 0;
        end else begin
          mw_row++;
        end
      end
    end
  end

  function automatic logic [W-1:0] row_seq(input int r);
    logic [W-1:0] d;
    for (int c = 0; c < N; c++) d[c*EW +: EW] = 8'(r * N + c);
    return d;
  endfunction

  function automatic logic [W-1:0] col_seq(input int v);
    logic [W-1:0] d;
    for (int i = 0; i < N; i++) d[i*EW +: EW] = 8'(i * N + v);
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp_t.delete(); exp_p.delete(); exp_l.delete();
    got_t.delete(); got_p.delete(); got_tl.delete(); got_pl.delete(); got_cyc.delete();
  endtask

  task automatic send_row(input logic [W-1:0] d, input logic [N-1:0] be, output int waits);
    logic ok;
    waits    = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    wr_be    = be;
    for (int k = 0; k < 300; k++) begin
      ok = t_wr_ready;
      tick();
      if (ok) return;
      waits++;
    end
    failures++;
    $display("FAIL send_row_timeout waited=%0d limit=300", waits);
  endtask

  task automatic drain(input int max);
    for (int k = 0; k < max; k++) begin
      if (got_t.size() >= exp_t.size() && got_p.size() >= exp_p.size()) break;
      tick();
    end
    tick();
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1; wr_valid = 1'b0; rd_ready = 1'b0; flush = 1'b0;
    tick(); tick();
    checks++;
    if ({t_rd_valid, t_rd_last, t_bank_full, t_wr_ready} !== 5'b00001) begin
      failures++; $display("FAIL reset_t_ctrl got=%b exp=00001", {t_rd_valid, t_rd_last, t_bank_full, t_wr_ready});
    end
    checks++;
    if ({p_rd_valid, p_rd_last, p_bank_full, p_wr_ready} !== 5'b00001) begin
      failures++; $display("FAIL reset_p_ctrl got=%b exp=00001", {p_rd_valid, p_rd_last, p_bank_full, p_wr_ready});
    end
    checks++;
    if (t_rd_data !== '0 || p_rd_data !== '0) begin
      failures++; $display("FAIL reset_rd_data got=%h/%h exp=0", t_rd_data, p_rd_data);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (t_wr_ready !== 1'b1 || t_rd_valid !== 1'b0) begin
      failures++; $display("FAIL reset_release got=%b%b exp=10", t_wr_ready, t_rd_valid);
    end
  endtask

  task automatic test_basic();
    int w;
    clear_q();
    rd_ready = 1'b1;
    for (int r = 0; r < N; r++) send_row(row_seq(r), '1, w);
    wr_valid = 1'b0;
    checks++;
    if (t_bank_full !== 2'b01 || t_rd_valid !== 1'b0) begin
      failures++; $display("FAIL basic_full got=%b/%b exp=01/0", t_bank_full, t_rd_valid);
    end
    tick();
    checks++;
    if (t_rd_valid !== 1'b1 || t_rd_data !== col_seq(0)) begin
      failures++; $display("FAIL basic_first_t got=%b/%h exp=1/%h", t_rd_valid, t_rd_data, col_seq(0));
    end
    checks++;
    if (p_rd_valid !== 1'b1 || p_rd_data !== row_seq(0)) begin
      failures++; $display("FAIL basic_first_p got=%b/%h exp=1/%h", p_rd_valid, p_rd_data, row_seq(0));
    end
    drain(40);
    checks++;
    if (got_t.size() != N || got_p.size() != N) begin
      failures++; $display("FAIL basic_count got=%0d/%0d exp=%0d", got_t.size(), got_p.size(), N);
    end else begin
      for (int v = 0; v < N; v++) begin
        checks++;
        if (got_t[v] !== col_seq(v) || got_tl[v] !== (v == N - 1)) begin
          failures++; $display("FAIL basic_t_vec%0d got=%h/%b exp=%h/%b", v, got_t[v], got_tl[v], col_seq(v), v == N - 1);
        end
        checks++;
        if (got_p[v] !== row_seq(v) || got_pl[v] !== (v == N - 1)) begin
          failures++; $display("FAIL basic_p_vec%0d got=%h/%b exp=%h/%b", v, got_p[v], got_pl[v], row_seq(v), v == N - 1);
        end
      end
    end
    checks++;
    if (t_bank_full !== 2'b00 || t_rd_valid !== 1'b0) begin
      failures++; $display("FAIL basic_idle got=%b/%b exp=00/0", t_bank_full, t_rd_valid);
    end
  endtask

  task automatic test_back_to_back();
    int w, total;
    clear_q();
    rd_ready = 1'b1;
    total    = 0;
    for (int r = 0; r < 4 * N; r++) begin
      send_row({$urandom, $urandom}, '1, w);
      total += w;
    end
    wr_valid = 1'b0;
    drain(60);
    checks++;
    if (total != 0) begin
      failures++; $display("FAIL b2b_wr_stalls got=%0d exp=0", total);
    end
    checks++;
    if (got_t.size() != 4 * N || exp_t.size() != 4 * N || got_p.size() != 4 * N) begin
      failures++; $display("FAIL b2b_count got=%0d/%0d exp=%0d", got_t.size(), got_p.size(), 4 * N);
    end else begin
      for (int k = 0; k < 4 * N; k++) begin
        checks++;
        if (got_t[k] !== exp_t[k] || got_p[k] !== exp_p[k] || got_tl[k] !== exp_l[k]) begin
          failures++; $display("FAIL b2b_vec%0d got=%h/%h/%b exp=%h/%h/%b", k, got_t[k], got_p[k], got_tl[k], exp_t[k], exp_p[k], exp_l[k]);
        end
        if (k > 0) begin
          checks++;
          if (got_cyc[k] != got_cyc[k-1] + 1) begin
            failures++; $display("FAIL b2b_bubble%0d got_gap=%0d exp_gap=1", k, got_cyc[k] - got_cyc[k-1]);
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int w;
    logic [W-1:0] r17;
    clear_q();
    rd_ready = 1'b0;
    for (int r = 0; r < 2 * N; r++) send_row({$urandom, $urandom}, '1, w);
    checks++;
    if (t_bank_full !== 2'b11 || t_wr_ready !== 1'b0) begin
      failures++; $display("FAIL bp_both_full got=%b/%b exp=11/0", t_bank_full, t_wr_ready);
    end
    r17      = {$urandom, $urandom};
    wr_valid = 1'b1;
    wr_data  = r17;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (t_wr_ready !== 1'b0 || t_rd_valid !== 1'b1 || t_rd_data !== exp_t[0] || p_rd_data !== exp_p[0]) begin
        failures++; $display("FAIL bp_hold%0d got=%b/%h exp=0/%h", k, t_wr_ready, t_rd_data, exp_t[0]);
      end
    end
    checks++;
    if (got_t.size() != 0) begin
      failures++; $display("FAIL bp_no_consume got=%0d exp=0", got_t.size());
    end
    rd_ready = 1'b1;
    for (int k = 1; k < N - 1; k++) begin
      tick();
      checks++;
      if (t_wr_ready !== 1'b0) begin
        failures++; $display("FAIL bp_early_ready%0d got=1 exp=0", k);
      end
    end
    tick();
    checks++;
    if (t_wr_ready !== 1'b1) begin
      failures++; $display("FAIL bp_ready_rise got=%b exp=1", t_wr_ready);
    end
    send_row(r17, '1, w);
    for (int r = 1; r < N; r++) send_row({$urandom, $urandom}, '1, w);
    wr_valid = 1'b0;
    drain(80);
    checks++;
    if (got_t.size() != 3 * N || exp_t.size() != 3 * N || got_p.size() != 3 * N) begin
      failures++; $display("FAIL bp_count got=%0d/%0d exp=%0d", got_t.size(), got_p.size(), 3 * N);
    end else begin
      for (int k = 0; k < 3 * N; k++) begin
        checks++;
        if (got_t[k] !== exp_t[k] || got_p[k] !== exp_p[k] || got_tl[k] !== exp_l[k]) begin
          failures++; $display("FAIL bp_vec%0d got=%h/%h exp=%h/%h", k, got_t[k], got_p[k], exp_t[k], exp_p[k]);
        end
      end
    end
  endtask

  task automatic test_byte_enable();
    int w;
    logic [W-1:0] aa, t_b, p_b;
    aa = {N{8'hAA}};
    pulse_reset();
    clear_q();
    rd_ready = 1'b1;
    for (int r = 0; r < N; r++) send_row(aa, '1, w);
    for (int r = 0; r < N; r++) send_row({$urandom, $urandom}, '1, w);
    for (int r = 0; r < N; r++) send_row({N{8'h55}}, 8'h0F, w);
    wr_valid = 1'b0;
    drain(80);
    checks++;
    if (got_t.size() != 3 * N || got_p.size() != 3 * N) begin
      failures++; $display("FAIL be_count got=%0d/%0d exp=%0d", got_t.size(), got_p.size(), 3 * N);
    end else begin
      for (int v = 0; v < N; v++) begin
        checks++;
        if (got_t[v] !== aa || got_p[v] !== aa) begin
          failures++; $display("FAIL be_blockA%0d got=%h/%h exp=%h", v, got_t[v], got_p[v], aa);
        end
        checks++;
        if (got_t[N+v] !== exp_t[N+v] || got_p[N+v] !== exp_p[N+v]) begin
          failures++; $display("FAIL be_blockX%0d got=%h/%h exp=%h/%h", v, got_t[N+v], got_p[N+v], exp_t[N+v], exp_p[N+v]);
        end
        t_b = (v < 4) ? {N{8'h55}} : aa;
        p_b = {{4{8'hAA}}, {4{8'h55}}};
        checks++;
        if (got_t[2*N+v] !== t_b || got_p[2*N+v] !== p_b) begin
          failures++; $display("FAIL be_blockB%0d got=%h/%h exp=%h/%h", v, got_t[2*N+v], got_p[2*N+v], t_b, p_b);
        end
      end
    end
  endtask

  task automatic test_flush();
    int w;
    logic [W-1:0] rows [N];
    logic [W-1:0] ev;
    clear_q();
    rd_ready = 1'b1;
    for (int r = 0; r < 3; r++) send_row({$urandom, $urandom}, '1, w);
    flush    = 1'b1;
    wr_valid = 1'b1;
    wr_data  = {$urandom, $urandom};
    tick();
    flush = 1'b0;
    for (int r = 0; r < N; r++) begin
      rows[r] = {$urandom, $urandom};
      send_row(rows[r], '1, w);
    end
    wr_valid = 1'b0;
    drain(40);
    checks++;
    if (got_t.size() != N || got_p.size() != N) begin
      failures++; $display("FAIL flush_count got=%0d/%0d exp=%0d", got_t.size(), got_p.size(), N);
    end else begin
      for (int v = 0; v < N; v++) begin
        for (int i = 0; i < N; i++) ev[i*EW +: EW] = rows[i][v*EW +: EW];
        checks++;
        if (got_t[v] !== ev || got_p[v] !== rows[v]) begin
          failures++; $display("FAIL flush_vec%0d got=%h/%h exp=%h/%h", v, got_t[v], got_p[v], ev, rows[v]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic         pv, pr;
    logic [W-1:0] pd;
    clear_q();
    for (int k = 0; k < 400; k++) begin
      wr_valid = ($urandom_range(3) != 0);
      wr_data  = {$urandom, $urandom};
      wr_be    = N'($urandom);
      flush    = ($urandom_range(40) == 0);
      rd_ready = ($urandom_range(2) != 0);
      pv = t_rd_valid; pr = rd_ready; pd = t_rd_data;
      tick();
      if (pv && !pr) begin
        checks++;
        if (t_rd_valid !== 1'b1 || t_rd_data !== pd) begin
          failures++; $display("FAIL rand_stall_hold%0d got=%b/%h exp=1/%h", k, t_rd_valid, t_rd_data, pd);
        end
      end
    end
    wr_valid = 1'b0; flush = 1'b0; rd_ready = 1'b1;
    drain(100);
    checks++;
    if (got_t.size() != exp_t.size() || got_p.size() != exp_p.size() || exp_t.size() == 0) begin
      failures++; $display("FAIL rand_count got=%0d/%0d exp=%0d", got_t.size(), got_p.size(), exp_t.size());
    end else begin
      for (int k = 0; k < exp_t.size(); k++) begin
        checks++;
        if (got_t[k] !== exp_t[k] || got_p[k] !== exp_p[k] || got_tl[k] !== exp_l[k] || got_pl[k] !== exp_l[k]) begin
          failures++; $display("FAIL rand_vec%0d got=%h/%h/%b exp=%h/%h/%b", k, got_t[k], got_p[k], got_tl[k], exp_t[k], exp_p[k], exp_l[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int w;
    pulse_reset();
    clear_q();
    rd_ready = 1'b0;
    for (int r = 0; r < N + 5; r++) send_row({$urandom, $urandom}, '1, w);
    wr_valid = 1'b0;
    rd_ready = 1'b1;
    tick(); tick();
    checks++;
    if (got_t.size() != 2 || t_rd_valid !== 1'b1) begin
      failures++; $display("FAIL mid_pre got=%0d/%b exp=2/1", got_t.size(), t_rd_valid);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({t_rd_valid, t_rd_last, t_bank_full, t_wr_ready} !== 5'b00001 || t_rd_data !== '0) begin
      failures++; $display("FAIL mid_async_t got=%b/%h exp=00001/0", {t_rd_valid, t_rd_last, t_bank_full, t_wr_ready}, t_rd_data);
    end
    checks++;
    if ({p_rd_valid, p_bank_full} !== 3'b000 || p_rd_data !== '0) begin
      failures++; $display("FAIL mid_async_p got=%b/%h exp=000/0", {p_rd_valid, p_bank_full}, p_rd_data);
    end
    tick();
    reset = 1'b0;
    tick();
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_byte_enable();
    test_flush();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
